// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, starvation limit and arbiter state encoding
package rf_pkg;
  localparam int D_WIDTH_DEF = 32;
  localparam int ADDRESS_WIDTH_DEF = 5;
  localparam int STARVE_LIMIT_DEF = 4;
  typedef enum logic {PRI0, PRI1} state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: two-entry synchronous FIFO holding port-1 writeback requests
module wb_fifo import rf_pkg::*; #(
  parameter int W = ADDRESS_WIDTH_DEF + D_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] count_q;
  always_ff @(posedge clk) if (push_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q ^ push_i;
      rd_q <= rd_q ^ pop_i;
      count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
  always_comb begin
    data_o = mem_q[rd_q];
    full_o = count_q == 2'd2;
    empty_o = count_q == 2'd0;
    count_o = count_q;
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-port register-file writeback arbiter with port-1 starvation guard
module rf_wb_arbiter import rf_pkg::*; #(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [D_WIDTH-1:0]       req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [D_WIDTH-1:0]       req1_data,
  output logic                     req1_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] a3,
  output logic [D_WIDTH-1:0]       din,
  output logic [1:0]               q1_count,
  output logic                     starve_active
);
  localparam int EW = ADDRESS_WIDTH + D_WIDTH;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  state_t state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [EW-1:0] head;
  logic [ADDRESS_WIDTH-1:0] ga;
  logic [D_WIDTH-1:0] gd;
  logic [1:0] count;
  logic empty, full, push, g0, g1;
  wb_fifo #(.W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(g1),
    .data_i({req1_addr, req1_data}),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(count)
  );
  always_comb begin
    req1_ready = !rst && !full;
    push = req1_valid && req1_ready;
    g1 = !rst && !empty && (state_q == PRI1 || !req0_valid);
    g0 = !rst && req0_valid && !g1;
    req0_ready = g0;
    {ga, gd} = g1 ? head : {req0_addr, req0_data};
    starve_d = g1 ? '0 : (!empty && starve_q != CW'(STARVE_LIMIT)) ? starve_q + CW'(1) : starve_q;
    // Switching on the updated count caps port 1 at exactly STARVE_LIMIT consecutive losses
    state_d = state_q == PRI1 ? (g1 ? PRI0 : PRI1) : (starve_d == CW'(STARVE_LIMIT) ? PRI1 : PRI0);
    starve_active = state_q == PRI1;
    q1_count = count;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PRI0;
      starve_q <= '0;
      wr_en <= 1'b0;
      a3 <= '0;
      din <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      wr_en <= (g0 || g1) && ga != '0;
      if (g0 || g1) begin
        a3 <= ga;
        din <= gd;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios checked against a queue-based arbitration model
module tb_rf_wb_arbiter;
  localparam int LIMIT = 4;
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, wr_en, starve_active;
  logic [4:0] a3;
  logic [31:0] din;
  logic [1:0] q1_count;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  logic [31:0] rf [32];
  ent_t mq[$];
  bit m_pri1 = 1'b0, m_wr = 1'b0;
  int m_loss = 0;
  logic [4:0] m_a3 = '0;
  logic [31:0] m_din = '0;
  always #5 clk = ~clk;
  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .a3(a3), .din(din), .q1_count(q1_count), .starve_active(starve_active)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic pos();
    @(posedge clk);
    #1;
  endtask
  task automatic neg();
    @(negedge clk);
  endtask
  always @(negedge clk) if (wr_en) rf[a3] <= din;
  always @(negedge clk) begin : model
    bit r1, g0, g1;
    ent_t e;
    if (chk_on) begin
      r1 = !rst && mq.size() < 2;
      g1 = !rst && mq.size() > 0 && (m_pri1 || !req0_valid);
      g0 = !rst && req0_valid && !g1;
      check("m_req0_ready", 64'(req0_ready), 64'(g0));
      check("m_req1_ready", 64'(req1_ready), 64'(r1));
      check("m_q1_count", 64'(q1_count), 64'(mq.size()));
      check("m_starve_active", 64'(starve_active), 64'(m_pri1));
      check("m_wr_en", 64'(wr_en), 64'(m_wr));
      check("m_a3", 64'(a3), 64'(m_a3));
      check("m_din", 64'(din), 64'(m_din));
      if (rst) begin
        mq.delete();
        m_pri1 = 1'b0;
        m_loss = 0;
        m_wr = 1'b0;
        m_a3 = '0;
        m_din = '0;
      end else begin
        e = g1 ? mq[0] : ent_t'({req0_addr, req0_data});
        m_wr = (g0 || g1) && e.a != 5'd0;
        if (g0 || g1) begin
          m_a3 = e.a;
          m_din = e.d;
        end
        if (g1) m_loss = 0;
        else if (mq.size() > 0) m_loss = m_loss < LIMIT ? m_loss + 1 : LIMIT;
        m_pri1 = m_pri1 ? !g1 : (m_loss == LIMIT);
        if (g1) void'(mq.pop_front());
        if (req1_valid && r1) mq.push_back(ent_t'({req1_addr, req1_data}));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end
  initial begin
    int wins, idx, hits;
    bit saw, done, full_seen, adv;
    logic [4:0] wq[$];
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    neg();
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_q1_count", 64'(q1_count), 64'd0);
    check("rst_starve", 64'(starve_active), 64'd0);
    pos();
    rst = 1'b0;
    req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    neg(); check("p0_ready", 64'(req0_ready), 64'd1);
    pos(); req0_valid = 0;
    neg();
    check("p0_wr_en", 64'(wr_en), 64'd1);
    check("p0_a3", 64'(a3), 64'd5);
    check("p0_din", 64'(din), 64'hDEADBEEF);
    pos();
    req0_valid = 1; req0_addr = 0; req0_data = 32'hFFFF;
    neg(); check("x0_ready", 64'(req0_ready), 64'd1);
    pos(); req0_valid = 0;
    neg();
    check("x0_wr_en", 64'(wr_en), 64'd0);
    check("x0_din", 64'(din), 64'hFFFF);
    pos();
    req0_valid = 1; req0_addr = 1; req0_data = 32'h100;
    req1_valid = 1; req1_addr = 7; req1_data = 32'h11;
    neg(); check("starve_push_ready", 64'(req1_ready), 64'd1);
    pos(); req1_valid = 0;
    wins = 0; saw = 0; done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      neg();
      if (q1_count != 0 && req0_ready) wins++;
      if (starve_active) saw = 1;
      if (wr_en && a3 == 5'd7) begin
        done = 1;
        check("starve_din", 64'(din), 64'h11);
        check("starve_resume_pri0", 64'(starve_active), 64'd0);
        check("starve_resume_p0", 64'(req0_ready), 64'd1);
      end
      pos();
    end
    check("starve_wins", 64'(wins), 64'd4);
    check("starve_seen", 64'(saw), 64'd1);
    check("starve_done", 64'(done), 64'd1);
    req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1; req1_addr = 5'(12 + i); req1_data = 32'h40 + 32'(i);
      neg();
      check("pp_ready", 64'(req1_ready), 64'd1);
      if (i > 0) check("pp_count", 64'(q1_count), 64'd1);
      if (i == 2) check("pp_a3_first", 64'(a3), 64'd12);
      pos();
    end
    req1_valid = 0;
    neg(); check("pp_a3_second", 64'(a3), 64'd13);
    pos();
    neg(); check("pp_a3_third", 64'(a3), 64'd14);
    pos();
    req0_valid = 1; req0_addr = 2; req0_data = 32'h200;
    idx = 0; full_seen = 0; wq.delete();
    for (int c = 0; c < 30; c++) begin
      if (c == 12) req0_valid = 0;
      req1_valid = idx < 3; req1_addr = 5'(9 + idx); req1_data = 32'h21 + 32'(idx);
      neg();
      if (q1_count == 2'd2 && !req1_ready && req1_valid) full_seen = 1;
      if (wr_en && a3 >= 5'd9 && a3 <= 5'd11) wq.push_back(a3);
      adv = req1_valid && req1_ready;
      pos();
      if (adv) idx++;
    end
    req1_valid = 0;
    check("bp_full_seen", 64'(full_seen), 64'd1);
    check("bp_pushed", 64'(idx), 64'd3);
    check("bp_writes", 64'(wq.size()), 64'd3);
    if (wq.size() == 3) begin
      check("bp_order0", 64'(wq[0]), 64'd9);
      check("bp_order1", 64'(wq[1]), 64'd10);
      check("bp_order2", 64'(wq[2]), 64'd11);
    end
    req0_valid = 1; req0_addr = 3; req0_data = 32'hA;
    req1_valid = 1; req1_addr = 3; req1_data = 32'hB;
    neg();
    check("same_p0_ready", 64'(req0_ready), 64'd1);
    check("same_p1_ready", 64'(req1_ready), 64'd1);
    pos(); req0_valid = 0; req1_valid = 0;
    neg();
    check("same_first_a3", 64'(a3), 64'd3);
    check("same_first_din", 64'(din), 64'hA);
    pos();
    neg();
    check("same_second_wr", 64'(wr_en), 64'd1);
    check("same_second_din", 64'(din), 64'hB);
    pos();
    neg(); check("same_rf_x3", 64'(rf[3]), 64'hB);
    pos();
    req0_valid = 1; req0_addr = 4; req0_data = 32'h300;
    for (int i = 0; i < 2; i++) begin
      req1_valid = 1; req1_addr = 5'(20 + i); req1_data = 32'h50 + 32'(i);
      pos();
    end
    req1_valid = 0;
    rst = 1;
    neg();
    check("rr_count_before", 64'(q1_count), 64'd2);
    check("rr_p0_ready", 64'(req0_ready), 64'd0);
    check("rr_p1_ready", 64'(req1_ready), 64'd0);
    pos();
    rst = 0; req0_valid = 0;
    neg();
    check("rr_wr_en", 64'(wr_en), 64'd0);
    check("rr_a3", 64'(a3), 64'd0);
    check("rr_din", 64'(din), 64'd0);
    check("rr_q1_count", 64'(q1_count), 64'd0);
    check("rr_starve", 64'(starve_active), 64'd0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      pos();
      neg();
      if (wr_en) hits++;
    end
    check("rr_no_write", 64'(hits), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
